// File: rtl/dma_pkg.sv
// dma_pkg: shared definitions for the stream-based DMA engines.
//   - FSM state encoding for the byte reader
//   - memory read latency and word geometry
//   - word_byte(): little-endian byte lane select from a 32-bit word
package dma_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_CAPT  = 3'd2;
  localparam logic [2:0] ST_SEND  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    FETCH = ST_FETCH,
    CAPT  = ST_CAPT,
    SEND  = ST_SEND,
    DONE  = ST_DONE
  } state_e;

  // The reader's FETCH->CAPT spacing assumes this latency.
  localparam int MEM_RD_LAT     = 1;
  localparam int BYTES_PER_WORD = 4;

  // Byte lane idx of w, lane 0 = bits [7:0].
  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/dma_byte_reader.sv
// dma_byte_reader: memory-to-stream DMA read engine.
// On start, reads 32-bit words from a 1-cycle-latency synchronous memory and
// emits the requested bytes little-endian on a valid/ready byte stream.
//
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   start          command strobe, only honoured in IDLE
//   base_addr      byte start address (may be unaligned), sampled with start
//   length         byte count (0 allowed), sampled with start
//   busy           high from the cycle after an accepted start through done
//   done           one-cycle completion pulse
//   mem_rd_en      memory read strobe
//   mem_addr       memory word address
//   mem_rd_data    memory read data, valid the cycle after mem_rd_en
//   m_valid/m_data/m_ready  byte stream master
module dma_byte_reader
  import dma_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-3:0] mem_addr,
  input  logic [31:0]       mem_rd_data,
  output logic              m_valid,
  output logic [7:0]        m_data,
  input  logic              m_ready
);

  state_e            r_state;
  logic [ADDR_W-3:0] r_word_addr;
  logic [1:0]        r_byte_idx;
  logic [LEN_W-1:0]  r_remaining;
  logic [31:0]       r_word;
  logic              r_busy;
  logic              r_done;
  logic              r_mem_rd_en;
  logic [ADDR_W-3:0] r_mem_addr;
  logic              r_m_valid;
  logic [7:0]        r_m_data;

  logic              w_hs;
  logic              w_last;
  logic              w_word_end;
  logic [1:0]        w_next_idx;
  logic [ADDR_W-3:0] w_next_word;

  assign w_hs        = r_m_valid && m_ready;
  assign w_last      = (r_remaining == {{(LEN_W-1){1'b0}}, 1'b1});
  assign w_word_end  = (r_byte_idx == 2'd3);
  assign w_next_idx  = r_byte_idx + 2'd1;
  assign w_next_word = r_word_addr + {{(ADDR_W-3){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_word_addr <= '0;
      r_byte_idx  <= '0;
      r_remaining <= '0;
      r_word      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_mem_rd_en <= 1'b0;
      r_mem_addr  <= '0;
      r_m_valid   <= 1'b0;
      r_m_data    <= '0;
    end else begin
      // Single-cycle strobes default low.
      r_done      <= 1'b0;
      r_mem_rd_en <= 1'b0;
      case (r_state)
        IDLE: begin
          r_busy <= 1'b0;
          if (start) begin
            r_word_addr <= base_addr[ADDR_W-1:2];
            r_byte_idx  <= base_addr[1:0];
            r_remaining <= length;
            r_busy      <= 1'b1;
            if (length != '0) begin
              // Read strobe is registered on entry so it is high during FETCH.
              r_mem_rd_en <= 1'b1;
              r_mem_addr  <= base_addr[ADDR_W-1:2];
              r_state     <= FETCH;
            end else begin
              r_done  <= 1'b1;
              r_state <= DONE;
            end
          end
        end
        FETCH: r_state <= CAPT;
        CAPT: begin
          // Data returns now; preload the first byte so m_valid rises registered.
          r_word    <= mem_rd_data;
          r_m_data  <= word_byte(mem_rd_data, r_byte_idx);
          r_m_valid <= 1'b1;
          r_state   <= SEND;
        end
        SEND: begin
          if (w_hs) begin
            r_remaining <= r_remaining - {{(LEN_W-1){1'b0}}, 1'b1};
            r_byte_idx  <= w_next_idx;
            if (w_last) begin
              r_m_valid <= 1'b0;
              r_done    <= 1'b1;
              r_state   <= DONE;
            end else if (w_word_end) begin
              // Lane 3 consumed: fetch the next word (address wraps naturally).
              r_word_addr <= w_next_word;
              r_mem_addr  <= w_next_word;
              r_mem_rd_en <= 1'b1;
              r_m_valid   <= 1'b0;
              r_state     <= FETCH;
            end else begin
              r_m_data <= word_byte(r_word, w_next_idx);
            end
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign mem_rd_en = r_mem_rd_en;
  assign mem_addr  = r_mem_addr;
  assign m_valid   = r_m_valid;
  assign m_data    = r_m_data;

endmodule

// File: tb/tb_dma_byte_reader.sv
// tb_dma_byte_reader: directed bench for dma_byte_reader with a 1-cycle
// memory model, a ready pattern generator and an 8-deep byte FIFO consumer.
module tb_dma_byte_reader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] base_addr;
  logic [15:0] length;
  logic        busy;
  logic        done;
  logic        mem_rd_en;
  logic [13:0] mem_addr;
  logic [31:0] mem_rd_data;
  logic        m_valid;
  logic [7:0]  m_data;
  logic        m_ready;

  dma_byte_reader #(.ADDR_W(16), .LEN_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .length(length), .busy(busy), .done(done), .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr), .mem_rd_data(mem_rd_data), .m_valid(m_valid),
    .m_data(m_data), .m_ready(m_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Memory model: 1-cycle synchronous read.
  logic [31:0] mem [0:3];
  initial begin
    mem[0] = 32'h44332211;
    mem[1] = 32'h88776655;
    mem[2] = 32'hCCBBAA99;
    mem[3] = 32'h00000000;
  end
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_addr[1:0]];

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Ready generation: 0 = always ready, 1 = pattern, 2 = FIFO not full.
  int rmode = 0;
  int pbase = 0;
  int rel   = 0;
  bit pat [0:6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  int fq[$];
  int fout[$];

  initial forever begin
    @(posedge clk); #2;
    case (rmode)
      0: m_ready = 1'b1;
      1: m_ready = (cyc >= pbase) ? pat[(cyc - pbase) % 7] : 1'b0;
      2: m_ready = (fq.size() < 8);
      default: m_ready = 1'b0;
    endcase
  end

  // Monitor, sampled mid-cycle.
  int   rx[$];
  int   rd_addr[$];
  int   rd_cnt = 0, done_cnt = 0, done_cyc = -1, last_hs = -1, first_v = -1;
  int   stall_seen = 0;
  bit   stall_prev = 0;
  logic [7:0] prev_d = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_prev) begin
        chk("hold_valid", {31'd0, m_valid}, 32'd1);
        chk("hold_data", {24'd0, m_data}, {24'd0, prev_d});
      end
      stall_prev = m_valid && !m_ready;
      prev_d     = m_data;
      if (m_valid && !m_ready && rmode == 2) stall_seen++;
      if (m_valid && first_v < 0) first_v = cyc;
      if (m_valid && m_ready) begin
        rx.push_back(int'(m_data));
        last_hs = cyc;
        if (rmode == 2) fq.push_back(int'(m_data));
      end
      if (rmode == 2 && cyc >= rel && fq.size() > 0) fout.push_back(fq.pop_front());
      if (mem_rd_en) begin rd_cnt++; rd_addr.push_back(int'(mem_addr)); end
      if (done) begin done_cnt++; done_cyc = cyc; end
    end else begin
      stall_prev = 0;
    end
  end

  task automatic clr();
    rx.delete(); rd_addr.delete(); fq.delete(); fout.delete();
    rd_cnt = 0; done_cnt = 0; done_cyc = -1; last_hs = -1; first_v = -1; stall_seen = 0;
  endtask

  task automatic do_start(input logic [15:0] b, input logic [15:0] l, output int t0);
    @(posedge clk); #1;
    base_addr = b; length = l; start = 1'b1;
    t0 = cyc; pbase = cyc + 3; rel = cyc + 20;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk("done_seen", {31'd0, seen}, 32'd1);
    #1;
  endtask

  task automatic chk_bytes(input string tag, input int got[$], input int exp[$]);
    chk({tag, "_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      chk(tag, (i < got.size()) ? got[i] : -1, exp[i]);
  endtask

  int t0;
  int exp8[$]  = '{'h11, 'h22, 'h33, 'h44, 'h55, 'h66, 'h77, 'h88};
  int exp3[$]  = '{'h44, 'h55, 'h66};
  int exp4[$]  = '{'h11, 'h22, 'h33, 'h44};
  int exp12[$] = '{'h11, 'h22, 'h33, 'h44, 'h55, 'h66, 'h77, 'h88, 'h99, 'hAA, 'hBB, 'hCC};

  task automatic chk_len8(input string tag);
    chk_bytes({tag, "_byte"}, rx, exp8);
    chk({tag, "_rd_cnt"}, rd_cnt, 2);
    chk({tag, "_rd0"}, (rd_addr.size() > 0) ? rd_addr[0] : -1, 0);
    chk({tag, "_rd1"}, (rd_addr.size() > 1) ? rd_addr[1] : -1, 1);
    chk({tag, "_first_v"}, first_v - t0, 3);
    chk({tag, "_done_lat"}, done_cyc - last_hs, 1);
    chk({tag, "_done_cnt"}, done_cnt, 1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; m_ready = 1'b0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_rd_en", {31'd0, mem_rd_en}, 32'd0);
    chk("rst_addr", {18'd0, mem_addr}, 32'd0);
    chk("rst_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_data", {24'd0, m_data}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: aligned, 8 bytes, always ready.
    clr(); rmode = 0;
    do_start(16'h0000, 16'd8, t0);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    wait_done(100);
    repeat (2) @(posedge clk); #1;
    chk_len8("t1");
    chk("t1_busy_end", {31'd0, busy}, 32'd0);

    // 2: unaligned base 3, 3 bytes spanning two words.
    clr();
    do_start(16'h0003, 16'd3, t0);
    wait_done(100);
    repeat (2) @(posedge clk); #1;
    chk_bytes("t2_byte", rx, exp3);
    chk("t2_rd_cnt", rd_cnt, 2);
    chk("t2_rd0", (rd_addr.size() > 0) ? rd_addr[0] : -1, 0);
    chk("t2_rd1", (rd_addr.size() > 1) ? rd_addr[1] : -1, 1);
    chk("t2_done_lat", done_cyc - last_hs, 1);

    // 3: ready pattern 1,0,0,1,1,0,1 from the first valid cycle.
    clr(); rmode = 1;
    do_start(16'h0000, 16'd4, t0);
    wait_done(100);
    repeat (2) @(posedge clk); #1;
    chk_bytes("t3_byte", rx, exp4);
    chk("t3_done_at", done_cyc - t0, 10);
    chk("t3_rd_cnt", rd_cnt, 1);
    rmode = 0;

    // 4a: zero length.
    clr();
    do_start(16'h0004, 16'd0, t0);
    wait_done(10);
    repeat (3) @(posedge clk); #1;
    chk("t4_done_at", done_cyc - t0, 1);
    chk("t4_rd_cnt", rd_cnt, 0);
    chk("t4_no_valid", first_v, -1);
    chk("t4_done_cnt", done_cnt, 1);

    // 4b: second start while busy is ignored.
    clr();
    do_start(16'h0000, 16'd8, t0);
    @(posedge clk); #1;
    base_addr = 16'h0004; length = 16'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(100);
    repeat (6) @(posedge clk); #1;
    chk_len8("t4b");

    // 5: reset after two bytes, then a fresh transfer.
    clr();
    do_start(16'h0000, 16'd8, t0);
    for (int i = 0; i < 50 && rx.size() < 2; i++) @(negedge clk);
    chk("t5_two_bytes", rx.size(), 2);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("t5_valid", {31'd0, m_valid}, 32'd0);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk); #1;
    chk("t5_no_done", done_cnt, 0);
    clr();
    do_start(16'h0000, 16'd8, t0);
    wait_done(100);
    repeat (2) @(posedge clk); #1;
    chk_len8("t5r");

    // 6: 8-deep FIFO, consumer held 20 cycles, 12 bytes.
    clr(); rmode = 2;
    do_start(16'h0000, 16'd12, t0);
    wait_done(300);
    for (int i = 0; i < 100 && fout.size() < 12; i++) @(negedge clk);
    #1;
    chk_bytes("t6_byte", fout, exp12);
    chk("t6_stalled", {31'd0, stall_seen > 0}, 32'd1);
    chk("t6_done_cnt", done_cnt, 1);
    chk("t6_rd_cnt", rd_cnt, 3);
    rmode = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dma_byte_reader.md
Name: dma_byte_reader

Overview:
Memory-to-stream DMA read engine. It is the producer side of the byte stream that the DMA test FIFO consumes.
- On a start command it reads 32-bit words from a synchronous memory with 1-cycle read latency.
- It unpacks each word little-endian and emits one byte per accepted handshake on a valid/ready byte stream.
- Sits between the test memory model and the byte FIFO input in the stream-based DMA sim.

Parameters:
ADDR_W, 16, byte-address width; word address is ADDR_W-2 bits
LEN_W, 16, transfer-length width in bytes

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle command strobe, sampled only in IDLE
base_addr  input  ADDR_W  byte start address, sampled with start; may be unaligned
length  input  LEN_W  byte count, sampled with start; 0 allowed
busy  output  1  high from the cycle after an accepted start until the done cycle inclusive
done  output  1  one-cycle pulse when the transfer completes
mem_rd_en  output  1  memory read strobe
mem_addr  output  ADDR_W-2  word address
mem_rd_data  input  32  read data, valid the cycle after mem_rd_en
m_valid  output  1  byte stream valid
m_data  output  8  byte stream data
m_ready  input  1  byte stream ready

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, named rst_n.
- Reset values: state=IDLE, busy=0, done=0, mem_rd_en=0, mem_addr=0, m_valid=0, m_data=0. Word register, byte index and remaining count are cleared.
- States: IDLE, FETCH, CAPT, SEND, DONE.
- IDLE:
  - start=1 latches word_addr=base_addr[ADDR_W-1:2], byte_idx=base_addr[1:0], remaining=length.
  - If length!=0, go to FETCH; if length==0, go to DONE.
- FETCH: mem_rd_en=1, mem_addr=word_addr, for exactly one cycle. Go to CAPT.
- CAPT: word_reg <= mem_rd_data. Go to SEND.
- SEND:
  - m_valid=1, m_data=word_reg[8*byte_idx +: 8].
  - On m_valid&&m_ready: remaining--, byte_idx++ (2-bit).
  - If remaining becomes 0, go to DONE.
  - Else if byte_idx was 3, word_addr++ (wraps modulo 2^(ADDR_W-2)) and go to FETCH.
  - Else stay in SEND.
- DONE: done=1 for one cycle, busy=1. Go to IDLE.
- Latency:
  - start at cycle T gives FETCH at T+1, capture at T+2, first m_valid at T+3.
  - Each word boundary inserts a 2-cycle bubble (FETCH, CAPT) with m_valid=0.
  - length==0: done at T+1, no memory read.
- Handshake rules:
  - m_valid is never withdrawn without a handshake.
  - m_data is stable while m_valid&&!m_ready.
  - m_valid is registered and has no combinational dependency on m_ready.
- start while busy (state != IDLE) is ignored; the in-flight transfer is unaffected.
- Each memory word is read at most once per transfer. Bytes below base_addr[1:0] in the first word are skipped. Bytes past the last one in the final word are discarded.
- Reset mid-transfer: immediate return to IDLE, m_valid drops asynchronously, no done pulse. The next start behaves as a fresh transfer.
- Widths: remaining is LEN_W bits, with no overflow since it only decrements from length. Byte index wrap 3→0 triggers the word-address increment.

Decomposition:
- Shared package dma_pkg: state encoding localparams (IDLE..DONE); MEM_RD_LAT=1; BYTES_PER_WORD=4.
- A separate sub-module is not warranted. An optional word_unpacker (32→8 byte mux plus index) is the only natural split; keep it inline unless it is reused by a future write engine.

Test Plan:
- Memory word 0 = 0x44332211, word 1 = 0x88776655. base=0x0000, len=8, m_ready=1 → bytes 11 22 33 44 55 66 77 88. Exactly two mem_rd_en pulses at addresses 0 and 1, done 1 cycle after the last handshake, first m_valid 3 cycles after start.
- Same memory, base=0x0003, len=3 → bytes 44 55 66. Reads at word 0 then word 1, done after byte 66.
- base=0, len=4, m_ready toggled 1,0,0,1,1,0,1 → m_data held constant across stalls. Sequence 11 22 33 44 with no drops or duplicates.
- len=0 → done at T+1, mem_rd_en never asserted, m_valid stays 0. A second start during a len=8 transfer leaves the output identical to the first test.
- rst_n asserted after 2 bytes of a len=8 transfer → m_valid=0, busy=0, no done. A restart then yields all 8 bytes in order.
- Stream connected to byte_fifo DEPTH=8 with its consumer stalled 20 cycles, len=12 → reader stalls while the FIFO is full. All 12 bytes drain in order after release, done exactly once.
